ifu_fetch_pc: RTL

Fetch-side PC generator and instruction queue that consumes the execute-stage branch unit's redirect (`bru_taken` / `bru_target`). It issues sequential instruction-memory requests and tracks outstanding fetches. On a taken branch or exception redirect it restarts fetch at the target and discards every stale in-flight response. Fetched words are buffered in a small in-order queue that feeds decode through a valid/ready handshake.

---
 rtl/ifu_fetch_pc.sv | 83 ++++++++
 1 files changed

// File: rtl/ifu_fetch_pc.sv
// ifu_fetch_pc: fetch PC generator with redirect-kill tracking and an in-order instruction queue
module ifu_fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        flush_out
);
    logic        redirect, accept, enq, deq;
    logic [31:0] target, pc, rsp_pc;
    logic [7:0]  outstanding, kill_cnt, live;
    logic [2:0]  count;
    logic [1:0]  rd_ptr, wr_ptr;
    logic [31:0] q_pc   [4];
    logic [31:0] q_inst [4];

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(FQ_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign redirect   = exc_valid | br_taken;
    assign target     = (exc_valid ? exc_target : br_target) & ~32'h3;
    assign flush_out  = redirect;
    assign live       = outstanding - kill_cnt + 8'(count);
    assign fetch_req  = resetn & ~redirect & (live < 8'(FQ_DEPTH));
    assign fetch_addr = pc;
    assign accept     = fetch_req & fetch_ack;
    assign enq        = fetch_rvalid & ~redirect & (kill_cnt == 8'd0);
    assign deq        = inst_valid & inst_ready & ~redirect;
    assign inst_valid = count != 3'd0;
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];

    // Live responses are sequential from the last redirect, so rsp_pc tracks the PC of the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= 8'd0;
            kill_cnt    <= 8'd0;
            count       <= 3'd0;
            rd_ptr      <= 2'd0;
            wr_ptr      <= 2'd0;
        end else if (redirect) begin
            pc          <= target;
            rsp_pc      <= target;
            outstanding <= outstanding - 8'(fetch_rvalid);
            kill_cnt    <= outstanding - 8'(fetch_rvalid);
            count       <= 3'd0;
            rd_ptr      <= 2'd0;
            wr_ptr      <= 2'd0;
        end else begin
            pc          <= accept ? pc + 32'd4 : pc;
            outstanding <= outstanding + 8'(accept) - 8'(fetch_rvalid);
            kill_cnt    <= (fetch_rvalid && kill_cnt != 8'd0) ? kill_cnt - 8'd1 : kill_cnt;
            rsp_pc      <= enq ? rsp_pc + 32'd4 : rsp_pc;
            wr_ptr      <= enq ? nxt(wr_ptr) : wr_ptr;
            rd_ptr      <= deq ? nxt(rd_ptr) : rd_ptr;
            count       <= count + 3'(enq) - 3'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[wr_ptr]   <= rsp_pc;
            q_inst[wr_ptr] <= fetch_rdata;
        end
    end
endmodule
